// File: rtl/scpad_pkg.sv
// scpad_pkg -- shared scratchpad types for the SRAM write path.
//   SCPAD_ADDR_WIDTH : SRAM row address width
//   SCPAD_ROW_W      : SRAM row width carried by sram_write_req_t
//   slot_state_e     : assembly slot lifecycle (FREE -> FILL -> DONE -> FREE)
//   xbar_desc_t      : crossbar descriptor travelling with a row
//   sram_write_req_t : fully assembled row handed to the backend
// Optional macro SCPAD_WRITE_MASK_EN adds a per-byte write mask to the request.
package scpad_pkg;

  localparam int SCPAD_ADDR_WIDTH = 16;
  localparam int SCPAD_ROW_W      = 512;

  typedef enum logic [1:0] {
    SLOT_FREE = 2'd0,
    SLOT_FILL = 2'd1,
    SLOT_DONE = 2'd2
  } slot_state_e;

  typedef struct packed {
    logic [3:0] bank;
    logic [3:0] shift;
  } xbar_desc_t;

  typedef struct packed {
    logic [SCPAD_ADDR_WIDTH-1:0] addr;
    xbar_desc_t                  xbar;
`ifdef SCPAD_WRITE_MASK_EN
    logic [SCPAD_ROW_W/8-1:0]    mask;
`endif
    logic [SCPAD_ROW_W-1:0]      data;
  } sram_write_req_t;

endpackage

// File: rtl/sram_write_rr_arbiter.sv
// sram_write_rr_arbiter -- combinational round-robin picker.
//   req   : one bit per slot that has a row ready
//   start : first index to consider (one past the last granted slot)
//   grant : one-hot grant, all zero when no request is pending
module sram_write_rr_arbiter #(
  parameter  int NUM_SLOTS = 4,
  localparam int SLOT_W    = $clog2(NUM_SLOTS)
) (
  input  logic [NUM_SLOTS-1:0] req,
  input  logic [SLOT_W-1:0]    start,
  output logic [NUM_SLOTS-1:0] grant
);

  always_comb begin
    int  idx;
    logic found;
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      idx = (int'(start) + i) % NUM_SLOTS;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sram_write_assembler.sv
// sram_write_assembler -- gathers DRAM read beats into full SRAM rows.
// Up to NUM_SLOTS rows assemble concurrently, each keyed by its DRAM id.
// Completed rows are offered to the backend round-robin through a registered
// request that holds steady while be_stall is high.
// Ports:
//   clk, rst (async, active-high)
//   alloc_valid/alloc_ready, alloc_id, alloc_xbar, alloc_spad_addr,
//   alloc_num_beats (beats minus one)     -- open a row
//   beat_valid, beat_id, beat_data        -- DRAM responses, never stalled
//   req_valid, be_stall, sram_write_req   -- assembled row to backend
//   req_latched                           -- pulse the cycle after accept
//   err_unmatched                         -- pulse for a dropped beat
// Optional macro SCPAD_WRITE_MASK_EN adds a byte mask covering filled beats.
module sram_write_assembler
  import scpad_pkg::*;
#(
  parameter  int BUS_W     = 64,
  parameter  int ROW_W     = 512,
  parameter  int NUM_SLOTS = 4,
  parameter  int ID_W      = 8,
  localparam int MAX_BEATS = ROW_W / BUS_W,
  localparam int CNT_W     = $clog2(MAX_BEATS),
  localparam int SLOT_W    = $clog2(NUM_SLOTS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        alloc_valid,
  output logic                        alloc_ready,
  input  logic [ID_W-1:0]             alloc_id,
  input  xbar_desc_t                  alloc_xbar,
  input  logic [SCPAD_ADDR_WIDTH-1:0] alloc_spad_addr,
  input  logic [CNT_W-1:0]            alloc_num_beats,
  input  logic                        beat_valid,
  input  logic [ID_W-1:0]             beat_id,
  input  logic [BUS_W-1:0]            beat_data,
  output logic                        req_valid,
  input  logic                        be_stall,
  output sram_write_req_t             sram_write_req,
  output logic                        req_latched,
  output logic                        err_unmatched
);

  slot_state_e                 state_q [NUM_SLOTS];
  logic [CNT_W-1:0]            cnt_q   [NUM_SLOTS];
  logic [ID_W-1:0]             id_q    [NUM_SLOTS];
  xbar_desc_t                  xbar_q  [NUM_SLOTS];
  logic [SCPAD_ADDR_WIDTH-1:0] addr_q  [NUM_SLOTS];
  logic [CNT_W-1:0]            nb_q    [NUM_SLOTS];
  logic [ROW_W-1:0]            data_q  [NUM_SLOTS];

  logic [SLOT_W-1:0]    rr_ptr_q, out_slot_q, alloc_sel, grant_idx;
  logic [NUM_SLOTS-1:0] free_vec, busy_hit, beat_hit, done_vec, rr_grant;
  logic                 alloc_fire, accept;
  sram_write_req_t      req_d;

  function automatic logic [ROW_W/8-1:0] beat_mask(input logic [CNT_W-1:0] nb);
    logic [ROW_W/8-1:0] m;
    for (int b = 0; b < ROW_W/8; b++)
      m[b] = (b < (int'(nb) + 1) * (BUS_W/8));
    return m;
  endfunction

  always_comb begin
    free_vec = '0;
    busy_hit = '0;
    beat_hit = '0;
    done_vec = '0;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      free_vec[s] = (state_q[s] == SLOT_FREE);
      busy_hit[s] = (state_q[s] != SLOT_FREE) && (id_q[s] == alloc_id);
      // Only FILL slots accept beats: a DONE slot or one being allocated
      // this very cycle (still FREE) lets the beat fall through as unmatched.
      beat_hit[s] = beat_valid && (state_q[s] == SLOT_FILL) && (id_q[s] == beat_id);
      done_vec[s] = (state_q[s] == SLOT_DONE);
    end
  end

  // Depends only on registered slot state, so a slot freed this cycle
  // becomes allocatable on the next one.
  assign alloc_ready = (|free_vec) && !(|busy_hit);
  assign alloc_fire  = alloc_valid && alloc_ready;
  assign accept      = req_valid && !be_stall;

  always_comb begin
    logic found;
    alloc_sel = '0;
    found     = 1'b0;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      if (!found && free_vec[s]) begin
        alloc_sel = SLOT_W'(s);
        found     = 1'b1;
      end
    end
  end

  sram_write_rr_arbiter #(.NUM_SLOTS(NUM_SLOTS)) u_rr (
    .req   (done_vec),
    .start (rr_ptr_q),
    .grant (rr_grant)
  );

  always_comb begin
    grant_idx = '0;
    for (int s = 0; s < NUM_SLOTS; s++)
      if (rr_grant[s]) grant_idx = SLOT_W'(s);
  end

  always_comb begin
    req_d      = '0;
    req_d.addr = addr_q[grant_idx];
    req_d.xbar = xbar_q[grant_idx];
    req_d.data = data_q[grant_idx];
`ifdef SCPAD_WRITE_MASK_EN
    req_d.mask = beat_mask(nb_q[grant_idx]);
`endif
  end

  // Slot payload: loaded on allocation, filled lane by lane; no reset needed
  // because allocation always clears the row before use.
  always_ff @(posedge clk) begin
    for (int s = 0; s < NUM_SLOTS; s++) begin
      if (alloc_fire && (alloc_sel == SLOT_W'(s))) begin
        id_q[s]   <= alloc_id;
        xbar_q[s] <= alloc_xbar;
        addr_q[s] <= alloc_spad_addr;
        nb_q[s]   <= alloc_num_beats;
        data_q[s] <= '0;
      end else if (beat_hit[s]) begin
        data_q[s][int'(cnt_q[s])*BUS_W +: BUS_W] <= beat_data;
      end
    end
  end

  // Slot lifecycle and output register. The output loads only when empty,
  // so the slot just accepted is already FREE before the next selection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < NUM_SLOTS; s++) begin
        state_q[s] <= SLOT_FREE;
        cnt_q[s]   <= '0;
      end
      rr_ptr_q       <= '0;
      out_slot_q     <= '0;
      req_valid      <= 1'b0;
      req_latched    <= 1'b0;
      err_unmatched  <= 1'b0;
      sram_write_req <= '0;
    end else begin
      req_latched   <= accept;
      err_unmatched <= beat_valid && !(|beat_hit);
      for (int s = 0; s < NUM_SLOTS; s++) begin
        case (state_q[s])
          SLOT_FREE: if (alloc_fire && (alloc_sel == SLOT_W'(s))) begin
            state_q[s] <= SLOT_FILL;
            cnt_q[s]   <= '0;
          end
          SLOT_FILL: if (beat_hit[s]) begin
            cnt_q[s] <= cnt_q[s] + CNT_W'(1);
            if (cnt_q[s] == nb_q[s]) state_q[s] <= SLOT_DONE;
          end
          SLOT_DONE: if (accept && (out_slot_q == SLOT_W'(s))) state_q[s] <= SLOT_FREE;
          default:   state_q[s] <= SLOT_FREE;
        endcase
      end
      if (accept) begin
        req_valid <= 1'b0;
        rr_ptr_q  <= (int'(out_slot_q) == NUM_SLOTS-1) ? '0 : out_slot_q + SLOT_W'(1);
      end else if (!req_valid && (|done_vec)) begin
        req_valid      <= 1'b1;
        out_slot_q     <= grant_idx;
        sram_write_req <= req_d;
      end
    end
  end

endmodule
